// File: rtl/dnn_pkg.sv
// Shared constants and helpers for the output-layer scoring blocks.
package dnn_pkg;

  localparam int CNT_W = 32;

  function automatic int beat_count(input int n, input int z);
    return n / z;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int min1_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Bit pattern of the most negative two's complement value of the given width.
  function automatic logic [63:0] most_neg(input int width);
    logic [63:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/max_finder_set.sv
// Combinational maximum over N signed lanes; the lowest lane index wins ties.
module max_finder_set
  import dnn_pkg::*;
#(
  parameter int width = 10,
  parameter int N     = 4,
  localparam int POS_W = min1_clog2(N)
) (
  input  logic [width*N-1:0] lanes,
  output logic [width-1:0]   max_val,
  output logic [POS_W-1:0]   max_pos
);

  always_comb begin
    max_val = lanes[width-1:0];
    max_pos = '0;
    for (int k = 1; k < N; k++) begin
      if ($signed(lanes[width*k +: width]) > $signed(max_val)) begin
        max_val = lanes[width*k +: width];
        max_pos = POS_W'(k);
      end
    end
  end

endmodule

// File: rtl/argmax_score_block.sv
// Streams n activations in beats of z, reports the argmax class per sample and
// scores it against a one-hot ideal output, keeping running totals.
module argmax_score_block
  import dnn_pkg::*;
#(
  parameter int width = 10,
  parameter int n     = 16,
  parameter int z     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  // No backpressure: every cycle with in_valid high at the edge consumes one beat.
  input  logic                 in_valid,
  input  logic [width*z-1:0]   in_act,
  input  logic [z-1:0]         in_ans,
  input  logic                 clear_counts,
  output logic                 out_valid,
  output logic [n-1:0]         out_onehot,
  output logic [$clog2(n)-1:0] out_idx,
  output logic                 out_correct,
  output logic                 ans_err,
  output logic [CNT_W-1:0]     total_count,
  output logic [CNT_W-1:0]     correct_count
);

  localparam int NB      = beat_count(n, z);
  localparam int BEAT_W  = min1_clog2(NB);
  localparam int IDX_W   = $clog2(n);
  localparam int POS_W   = min1_clog2(z);
  localparam int LANE_SH = $clog2(z);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);
  localparam logic [width-1:0]  MOST_NEG  = width'(most_neg(width));
  localparam logic [n-1:0]      ONE_HOT0  = n'(1);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [width-1:0]  run_max_q, run_max_d;
  logic [IDX_W-1:0]  run_idx_q, run_idx_d;
  logic [IDX_W-1:0]  ans_idx_q, ans_idx_d;
  logic [1:0]        ans_cnt_q, ans_cnt_d;

  logic              out_valid_q, out_valid_d;
  logic [n-1:0]      out_onehot_q, out_onehot_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_correct_q, out_correct_d;
  logic              ans_err_q, ans_err_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  correct_q, correct_d;

  logic [width-1:0]  beat_max;
  logic [POS_W-1:0]  beat_pos;

  max_finder_set #(
    .width (width),
    .N     (z)
  ) u_lane_max (
    .lanes   (in_act),
    .max_val (beat_max),
    .max_pos (beat_pos)
  );

  // Merge of the current beat into the running sample state.
  logic              first_beat;
  logic              last_beat;
  logic [IDX_W-1:0]  beat_base;
  logic [width-1:0]  base_max;
  logic [width-1:0]  merged_max;
  logic [IDX_W-1:0]  merged_idx;
  logic [IDX_W-1:0]  merged_ans_idx;
  logic [1:0]        merged_cnt;
  logic              merged_err;

  always_comb begin
    first_beat = (beat_q == '0);
    last_beat  = (beat_q == LAST_BEAT);
    beat_base  = IDX_W'(beat_q) << LANE_SH;
    base_max   = first_beat ? MOST_NEG : run_max_q;

    merged_max = base_max;
    merged_idx = first_beat ? '0 : run_idx_q;
    // Beat 0 loads unconditionally so an all-most-negative sample still names lane 0.
    if (first_beat || ($signed(beat_max) > $signed(base_max))) begin
      merged_max = beat_max;
      merged_idx = beat_base | IDX_W'(beat_pos);
    end

    merged_cnt     = first_beat ? 2'd0 : ans_cnt_q;
    merged_ans_idx = first_beat ? '0 : ans_idx_q;
    for (int k = 0; k < z; k++) begin
      if (in_ans[k]) begin
        if (merged_cnt == 2'd0) merged_ans_idx = beat_base | IDX_W'(k);
        if (merged_cnt != 2'd2) merged_cnt = merged_cnt + 2'd1;
      end
    end
    merged_err = (merged_cnt != 2'd1);
  end

  always_comb begin
    beat_d        = beat_q;
    run_max_d     = run_max_q;
    run_idx_d     = run_idx_q;
    ans_idx_d     = ans_idx_q;
    ans_cnt_d     = ans_cnt_q;
    out_valid_d   = 1'b0;
    out_onehot_d  = out_onehot_q;
    out_idx_d     = out_idx_q;
    out_correct_d = out_correct_q;
    ans_err_d     = ans_err_q;
    total_d       = total_q;
    correct_d     = correct_q;

    if (in_valid) begin
      beat_d    = last_beat ? '0 : beat_q + BEAT_W'(1);
      run_max_d = merged_max;
      run_idx_d = merged_idx;
      ans_idx_d = merged_ans_idx;
      ans_cnt_d = merged_cnt;
      if (last_beat) begin
        out_valid_d   = 1'b1;
        out_idx_d     = merged_idx;
        out_onehot_d  = ONE_HOT0 << merged_idx;
        ans_err_d     = merged_err;
        out_correct_d = !merged_err && (merged_ans_idx == merged_idx);
      end
    end

    // Counters absorb the result on the cycle it is presented.
    if (out_valid_q) begin
      if (clear_counts) begin
        total_d   = CNT_W'(1);
        correct_d = CNT_W'(out_correct_q);
      end else begin
        if (total_q != '1) total_d = total_q + CNT_W'(1);
        if (out_correct_q && (correct_q != '1)) correct_d = correct_q + CNT_W'(1);
      end
    end else if (clear_counts) begin
      total_d   = '0;
      correct_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q        <= '0;
      run_max_q     <= MOST_NEG;
      run_idx_q     <= '0;
      ans_idx_q     <= '0;
      ans_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      out_onehot_q  <= '0;
      out_idx_q     <= '0;
      out_correct_q <= 1'b0;
      ans_err_q     <= 1'b0;
      total_q       <= '0;
      correct_q     <= '0;
    end else begin
      beat_q        <= beat_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      ans_idx_q     <= ans_idx_d;
      ans_cnt_q     <= ans_cnt_d;
      out_valid_q   <= out_valid_d;
      out_onehot_q  <= out_onehot_d;
      out_idx_q     <= out_idx_d;
      out_correct_q <= out_correct_d;
      ans_err_q     <= ans_err_d;
      total_q       <= total_d;
      correct_q     <= correct_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_onehot    = out_onehot_q;
  assign out_idx       = out_idx_q;
  assign out_correct   = out_correct_q;
  assign ans_err       = ans_err_q;
  assign total_count   = total_q;
  assign correct_count = correct_q;

endmodule

// File: tb/tb_argmax_score_block.sv
// Bench for argmax_score_block: an n=16/z=4 instance and an n=z=4 instance share
// one input stream and are checked every cycle against a sample-level model.
module tb_argmax_score_block;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [39:0] in_act;
  logic [3:0]  in_ans;
  logic        clear_counts;

  logic        ov0, oc0, ae0;
  logic [15:0] oh0;
  logic [3:0]  oi0;
  logic [31:0] tc0, cc0;
  logic        ov1, oc1, ae1;
  logic [3:0]  oh1;
  logic [1:0]  oi1;
  logic [31:0] tc1, cc1;

  argmax_score_block #(.width(10), .n(16), .z(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_act(in_act), .in_ans(in_ans),
    .clear_counts(clear_counts), .out_valid(ov0), .out_onehot(oh0), .out_idx(oi0),
    .out_correct(oc0), .ans_err(ae0), .total_count(tc0), .correct_count(cc0)
  );

  argmax_score_block #(.width(10), .n(4), .z(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_act(in_act), .in_ans(in_ans),
    .clear_counts(clear_counts), .out_valid(ov1), .out_onehot(oh1), .out_idx(oi1),
    .out_correct(oc1), .ans_err(ae1), .total_count(tc1), .correct_count(cc1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit     e_valid[2];
  longint e_oh[2];
  int     e_idx[2];
  bit     e_err[2];
  bit     e_corr[2];
  longint e_tot[2];
  longint e_cc[2];
  int     acc_v[2][16];
  bit     acc_a[2][16];
  int     fill[2];

  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  task automatic score_sample(input int u, input int nn);
    int best;
    int cnt;
    int aidx;
    best = 0;
    for (int i = 1; i < nn; i++) if (acc_v[u][i] > acc_v[u][best]) best = i;
    cnt  = 0;
    aidx = -1;
    for (int i = 0; i < nn; i++) begin
      if (acc_a[u][i]) begin
        cnt++;
        if (aidx < 0) aidx = i;
      end
    end
    e_idx[u]  = best;
    e_oh[u]   = longint'(1) << best;
    e_err[u]  = (cnt != 1);
    e_corr[u] = (cnt == 1) && (aidx == best);
  endtask

  task automatic model_step(input int u, input int nn);
    logic signed [9:0] v;
    if (reset) begin
      fill[u] = 0; e_valid[u] = 0; e_oh[u] = 0; e_idx[u] = 0;
      e_err[u] = 0; e_corr[u] = 0; e_tot[u] = 0; e_cc[u] = 0;
      return;
    end
    if (e_valid[u]) begin
      if (clear_counts) begin
        e_tot[u] = 1;
        e_cc[u]  = e_corr[u];
      end else begin
        if (e_tot[u] < CNT_MAX) e_tot[u]++;
        if (e_corr[u] && e_cc[u] < CNT_MAX) e_cc[u]++;
      end
    end else if (clear_counts) begin
      e_tot[u] = 0;
      e_cc[u]  = 0;
    end
    e_valid[u] = 0;
    if (in_valid) begin
      for (int k = 0; k < 4; k++) begin
        v = in_act[10*k +: 10];
        acc_v[u][fill[u]+k] = v;
        acc_a[u][fill[u]+k] = in_ans[k];
      end
      fill[u] += 4;
      if (fill[u] == nn) begin
        score_sample(u, nn);
        e_valid[u] = 1;
        fill[u]    = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 16);
    model_step(1, 4);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0_valid", ov0, e_valid[0]);
      chk("u0_onehot", oh0, e_oh[0]);
      chk("u0_idx", oi0, e_idx[0]);
      chk("u0_correct", oc0, e_corr[0]);
      chk("u0_ans_err", ae0, e_err[0]);
      chk("u0_total", tc0, e_tot[0]);
      chk("u0_correct_cnt", cc0, e_cc[0]);
      chk("u1_valid", ov1, e_valid[1]);
      chk("u1_onehot", oh1, e_oh[1]);
      chk("u1_idx", oi1, e_idx[1]);
      chk("u1_correct", oc1, e_corr[1]);
      chk("u1_ans_err", ae1, e_err[1]);
      chk("u1_total", tc1, e_tot[1]);
      chk("u1_correct_cnt", cc1, e_cc[1]);
    end
  end

  // ---------------- driver ----------------
  int sv[16];
  bit sa[16];

  task automatic cyc(input bit v, input logic [39:0] a, input logic [3:0] s, input bit c);
    in_valid = v; in_act = a; in_ans = s; clear_counts = c;
    @(negedge clk);
    in_valid = 1'b0; clear_counts = 1'b0;
  endtask

  function automatic logic [39:0] pack_beat(input int b);
    logic [39:0] r;
    logic [9:0]  t;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      t = 10'(sv[4*b+k]);
      r[10*k +: 10] = t;
    end
    return r;
  endfunction

  function automatic logic [3:0] ans_beat(input int b);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = sa[4*b+k];
    return r;
  endfunction

  task automatic set_all(input int v);
    for (int i = 0; i < 16; i++) begin
      sv[i] = v;
      sa[i] = 1'b0;
    end
  endtask

  task automatic send_sample(input int gap);
    for (int b = 0; b < 4; b++) begin
      cyc(1'b1, pack_beat(b), ans_beat(b), 1'b0);
      if (b < 3) repeat (gap) cyc(1'b0, '0, '0, 1'b0);
    end
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_act = '0; in_ans = '0; clear_counts = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_valid", ov0, 0);
    chk("rst_onehot", oh0, 0);
    chk("rst_idx", oi0, 0);
    chk("rst_total", tc0, 0);
    chk("rst_correct_cnt", cc0, 0);
    reset = 1'b0;

    // Single winner in beat 2.
    set_all(-5); sv[9] = 3; sa[9] = 1;
    send_sample(0);
    chk("s034_valid", ov0, 1);
    chk("s034_idx", oi0, 9);
    chk("s034_onehot", oh0, 16'h0200);
    chk("s034_correct", oc0, 1);
    chk("s034_model_idx", e_idx[0], 9);
    idle();
    chk("s034_total", tc0, 1);
    chk("s034_correct_cnt", cc0, 1);

    // Tie across beats: lowest index wins.
    cyc(1'b0, '0, '0, 1'b1);
    set_all(0); sv[2] = 100; sv[13] = 100; sa[13] = 1;
    send_sample(0);
    chk("s035_idx", oi0, 2);
    chk("s035_correct", oc0, 0);
    idle();
    chk("s035_total", tc0, 1);
    chk("s035_correct_cnt", cc0, 0);

    // Max in the final beat with gaps between beats.
    set_all(0); sv[15] = 50; sa[15] = 1;
    send_sample(3);
    chk("s036_valid", ov0, 1);
    chk("s036_idx", oi0, 15);
    idle();
    chk("s036_valid_drop", ov0, 0);

    // Malformed answers.
    cyc(1'b0, '0, '0, 1'b1);
    set_all(1);
    send_sample(0);
    chk("s037a_err", ae0, 1);
    chk("s037a_correct", oc0, 0);
    idle();
    chk("s037a_total", tc0, 1);
    sv[4] = 9; sa[4] = 1; sa[7] = 1;
    send_sample(0);
    chk("s037b_err", ae0, 1);
    chk("s037b_correct", oc0, 0);
    chk("s037b_idx", oi0, 4);
    idle();
    chk("s037b_total", tc0, 2);
    chk("s037b_correct_cnt", cc0, 0);

    // Reset mid-sample, overriding valid and clear.
    set_all(0); sv[5] = 400; sa[5] = 1;
    for (int b = 0; b < 3; b++) cyc(1'b1, pack_beat(b), ans_beat(b), 1'b0);
    reset = 1'b1;
    cyc(1'b1, 40'hFF_FFFF_FFFF, 4'hF, 1'b1);
    reset = 1'b0;
    chk("s038_rst_valid", ov0, 0);
    chk("s038_rst_total", tc0, 0);
    set_all(0); sv[11] = 200; sa[11] = 1;
    send_sample(0);
    chk("s038_valid", ov0, 1);
    chk("s038_idx", oi0, 11);
    chk("s038_correct", oc0, 1);
    idle();
    chk("s038_single_valid", ov0, 0);
    chk("s038_total", tc0, 1);
    chk("s038_correct_cnt", cc0, 1);

    // Clear coinciding with the result cycle of a correct sample.
    set_all(-1); sv[0] = 7; sa[0] = 1;
    send_sample(0);
    chk("s039_valid", ov0, 1);
    chk("s039_correct", oc0, 1);
    cyc(1'b0, '0, '0, 1'b1);
    chk("s039_total", tc0, 1);
    chk("s039_correct_cnt", cc0, 1);

    // n = z: every beat is a sample, results back to back.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 40'($urandom()) ^ (40'($urandom()) << 32), 4'($urandom_range(0, 15)), 1'b0);
      chk("s039_b2b_valid", ov1, 1);
    end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int mode;
      int best;
      bit v;
      bit clr;
      logic [3:0] s;
      logic [39:0] a;
      mode = $urandom_range(0, 9);
      for (int k = 0; k < 4; k++) begin
        if (mode < 6)      sv[k] = int'($urandom_range(0, 1023)) - 512;
        else if (mode < 9) sv[k] = int'($urandom_range(0, 4)) - 2;
        else               sv[k] = -512;
      end
      best = 0;
      for (int k = 1; k < 4; k++) if (sv[k] > sv[best]) best = k;
      case ($urandom_range(0, 4))
        0, 1:    s = 4'b0001 << best;
        2, 3:    s = 4'b0000;
        default: s = 4'($urandom_range(0, 15));
      endcase
      for (int k = 0; k < 4; k++) sa[k] = s[k];
      a   = pack_beat(0);
      v   = ($urandom_range(0, 99) < 70);
      clr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        cyc(v, a, s, clr);
        reset = 1'b0;
      end else begin
        cyc(v, a, s, clr);
      end
    end
    repeat (3) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
